// File: rtl/custom_axi_pkg.sv
// Shared constants, state types and the byte-strobe merge helper for the
// custom IP AXI-Lite register interface.
package custom_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [11:0] REG0_OFFSET = 12'h000;
    localparam logic [11:0] REG1_OFFSET = 12'h004;
    localparam logic [11:0] REG2_OFFSET = 12'h008;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic [0:0] {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/custom_axi_regif_wr.sv
// Write channel: one-entry AW and W buffers, write FSM, and the registered
// reg2ip strobes. Shadow storage lives in the parent; commit is exported to it.
//
// state  | meaning
// W_IDLE | accepting AW/W; commits on the edge where both are available
// W_RESP | bvalid held until bready; no new AW/W accepted
module custom_axi_regif_wr
    import custom_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_REGS   = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [ADDR_WIDTH-1:0]      awaddr_i,
    input  logic                       awvalid_i,
    output logic                       awready_o,
    input  logic [31:0]                wdata_i,
    input  logic [3:0]                 wstrb_i,
    input  logic                       wvalid_i,
    output logic                       wready_o,
    output logic [1:0]                 bresp_o,
    output logic                       bvalid_o,
    input  logic                       bready_i,
    input  logic [NUM_REGS-1:0][31:0]  shadow_i,
    output logic [NUM_REGS-1:0]        commit_en_o,
    output logic [31:0]                commit_data_o,
    output logic [NUM_REGS-1:0][31:0]  reg2ip_data_o,
    output logic [NUM_REGS-1:0]        reg2ip_en_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    wr_state_e        state_q;
    logic             aw_full_q;
    logic             w_full_q;
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;

    logic             aw_hs;
    logic             w_hs;
    logic             commit;
    logic             idx_ok;
    logic [IDX_W-1:0] cur_idx;
    logic [31:0]      cur_data;
    logic [3:0]       cur_strb;
    logic [31:0]      cur_old;
    logic [1:0]       unused_awaddr_lsb;

    assign unused_awaddr_lsb = awaddr_i[1:0];

    assign awready_o = rst_ni && (state_q == W_IDLE) && !aw_full_q;
    assign wready_o  = rst_ni && (state_q == W_IDLE) && !w_full_q;
    assign aw_hs     = awvalid_i && awready_o;
    assign w_hs      = wvalid_i && wready_o;

    // A buffered beat takes precedence over the bus, which is not ready anyway.
    assign commit   = (state_q == W_IDLE) && (aw_full_q || aw_hs) && (w_full_q || w_hs);
    assign cur_idx  = aw_full_q ? aw_idx_q : awaddr_i[ADDR_WIDTH-1:2];
    assign cur_data = w_full_q ? w_data_q : wdata_i;
    assign cur_strb = w_full_q ? w_strb_q : wstrb_i;

    always_comb begin
        cur_old     = '0;
        idx_ok      = 1'b0;
        commit_en_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (cur_idx == IDX_W'(i)) begin
                cur_old        = shadow_i[i];
                idx_ok         = 1'b1;
                commit_en_o[i] = commit;
            end
        end
    end

    assign commit_data_o = apply_wstrb(cur_old, cur_data, cur_strb);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= W_IDLE;
            aw_full_q     <= 1'b0;
            w_full_q      <= 1'b0;
            aw_idx_q      <= '0;
            w_data_q      <= '0;
            w_strb_q      <= '0;
            bvalid_o      <= 1'b0;
            bresp_o       <= RESP_OKAY;
            reg2ip_en_o   <= '0;
            reg2ip_data_o <= '0;
        end else begin
            reg2ip_en_o <= commit_en_o;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_en_o[i]) begin
                    reg2ip_data_o[i] <= commit_data_o;
                end
            end

            case (state_q)
                W_IDLE: begin
                    if (commit) begin
                        state_q   <= W_RESP;
                        bvalid_o  <= 1'b1;
                        bresp_o   <= idx_ok ? RESP_OKAY : RESP_SLVERR;
                        aw_full_q <= 1'b0;
                        w_full_q  <= 1'b0;
                    end else begin
                        if (aw_hs) begin
                            aw_full_q <= 1'b1;
                            aw_idx_q  <= awaddr_i[ADDR_WIDTH-1:2];
                        end
                        if (w_hs) begin
                            w_full_q <= 1'b1;
                            w_data_q <= wdata_i;
                            w_strb_q <= wstrb_i;
                        end
                    end
                end
                W_RESP: begin
                    if (bready_i) begin
                        bvalid_o <= 1'b0;
                        state_q  <= W_IDLE;
                    end
                end
                default: state_q <= W_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/custom_axi_regif.sv
// AXI4-Lite register interface for the custom IP core: shadow registers,
// read channel, and the write channel sub-block driving reg2ip strobes.
//
// state  | meaning
// R_IDLE | arready high; AR handshake registers read data
// R_RESP | rvalid/rdata/rresp held until rready
module custom_axi_regif
    import custom_axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [ADDR_WIDTH-1:0]        awaddr_i,
    input  logic                         awvalid_i,
    output logic                         awready_o,
    input  logic [DATA_WIDTH-1:0]        wdata_i,
    input  logic [DATA_WIDTH/8-1:0]      wstrb_i,
    input  logic                         wvalid_i,
    output logic                         wready_o,
    output logic [1:0]                   bresp_o,
    output logic                         bvalid_o,
    input  logic                         bready_i,
    input  logic [ADDR_WIDTH-1:0]        araddr_i,
    input  logic                         arvalid_i,
    output logic                         arready_o,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic [1:0]                   rresp_o,
    output logic                         rvalid_o,
    input  logic                         rready_i,
    output logic [NUM_REGS-1:0][31:0]    reg2ip_data_o,
    output logic [NUM_REGS-1:0]          reg2ip_en_o,
    input  logic [NUM_REGS-1:0][31:0]    ip2reg_data_i,
    input  logic [NUM_REGS-1:0]          ip2reg_en_i
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    if (DATA_WIDTH != 32) begin : g_data_width_check
        $error("custom_axi_regif: DATA_WIDTH must be 32");
    end

    logic [NUM_REGS-1:0][31:0] shadow_q;
    logic [NUM_REGS-1:0]       commit_en;
    logic [31:0]               commit_data;

    rd_state_e        rd_state_q;
    logic [IDX_W-1:0] ar_idx;
    logic [31:0]      rd_val;
    logic             rd_ok;
    logic [1:0]       unused_araddr_lsb;

    custom_axi_regif_wr #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_wr (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .awaddr_i      (awaddr_i),
        .awvalid_i     (awvalid_i),
        .awready_o     (awready_o),
        .wdata_i       (wdata_i),
        .wstrb_i       (wstrb_i),
        .wvalid_i      (wvalid_i),
        .wready_o      (wready_o),
        .bresp_o       (bresp_o),
        .bvalid_o      (bvalid_o),
        .bready_i      (bready_i),
        .shadow_i      (shadow_q),
        .commit_en_o   (commit_en),
        .commit_data_o (commit_data),
        .reg2ip_data_o (reg2ip_data_o),
        .reg2ip_en_o   (reg2ip_en_o)
    );

    // Bus commit has priority over a same-edge hardware update.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            shadow_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (commit_en[i]) begin
                    shadow_q[i] <= commit_data;
                end else if (ip2reg_en_i[i]) begin
                    shadow_q[i] <= ip2reg_data_i[i];
                end
            end
        end
    end

    assign unused_araddr_lsb = araddr_i[1:0];
    assign ar_idx            = araddr_i[ADDR_WIDTH-1:2];
    assign arready_o         = rst_ni && (rd_state_q == R_IDLE);

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IDX_W'(i)) begin
                rd_val = shadow_q[i];
                rd_ok  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_state_q <= R_IDLE;
            rvalid_o   <= 1'b0;
            rdata_o    <= '0;
            rresp_o    <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (arvalid_i) begin
                        rdata_o    <= rd_ok ? rd_val : '0;
                        rresp_o    <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                        rvalid_o   <= 1'b1;
                        rd_state_q <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (rready_i) begin
                        rvalid_o   <= 1'b0;
                        rd_state_q <= R_IDLE;
                    end
                end
                default: rd_state_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_custom_axi_regif.sv
// Scoreboard bench for custom_axi_regif: tasks push expected B/R/strobe
// events from a register-array model; a negedge monitor pops and compares.
module tb_custom_axi_regif;
    import custom_axi_pkg::*;

    localparam int NREG = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [11:0]       awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [11:0]       araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [NREG-1:0][31:0] reg2ip_data;
    logic [NREG-1:0]       reg2ip_en;
    logic [NREG-1:0][31:0] ip2reg_data = '0;
    logic [NREG-1:0]       ip2reg_en = '0;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [NREG];
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [34:0] exp_s [$];

    custom_axi_regif #(
        .ADDR_WIDTH (12),
        .DATA_WIDTH (32),
        .NUM_REGS   (NREG)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .awaddr_i      (awaddr),
        .awvalid_i     (awvalid),
        .awready_o     (awready),
        .wdata_i       (wdata),
        .wstrb_i       (wstrb),
        .wvalid_i      (wvalid),
        .wready_o      (wready),
        .bresp_o       (bresp),
        .bvalid_o      (bvalid),
        .bready_i      (bready),
        .araddr_i      (araddr),
        .arvalid_i     (arvalid),
        .arready_o     (arready),
        .rdata_o       (rdata),
        .rresp_o       (rresp),
        .rvalid_o      (rvalid),
        .rready_i      (rready),
        .reg2ip_data_o (reg2ip_data),
        .reg2ip_en_o   (reg2ip_en),
        .ip2reg_data_i (ip2reg_data),
        .ip2reg_en_i   (ip2reg_en)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    function automatic void fail(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h, expected no such event", name, act);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (bvalid && bready) begin
                if (exp_b.size() == 0) fail("unexpected_b", 64'(bresp));
                else check("bresp", 64'(bresp), 64'(exp_b.pop_front()));
            end
            if (rvalid && rready) begin
                if (exp_r.size() == 0) fail("unexpected_r", 64'({rdata, rresp}));
                else check("rdata_rresp", 64'({rdata, rresp}), 64'(exp_r.pop_front()));
            end
            if (reg2ip_en != '0) begin
                logic [31:0] d;
                d = '0;
                for (int i = 0; i < NREG; i++) if (reg2ip_en[i]) d = reg2ip_data[i];
                if (exp_s.size() == 0) fail("unexpected_strobe", 64'({reg2ip_en, d}));
                else check("strobe", 64'({reg2ip_en, d}), 64'(exp_s.pop_front()));
            end
        end
    end

    task automatic bus_write(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly,
                             input bit clash, input logic [31:0] clash_data);
        int          idx;
        logic [31:0] mask;
        logic [NREG-1:0] exp_en;
        bit aw_todo, w_todo, aw_fire, w_fire, b_fire;
        idx    = int'(addr[11:2]);
        exp_en = '0;
        mask   = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        if (idx < NREG) begin
            model[idx] = (model[idx] & ~mask) | (data & mask);
            exp_en[idx] = 1'b1;
            exp_s.push_back({exp_en, model[idx]});
            exp_b.push_back(RESP_OKAY);
        end else begin
            exp_b.push_back(RESP_SLVERR);
        end
        aw_todo = 1'b1;
        w_todo  = 1'b1;
        for (int cyc = 0; cyc < 100 && (aw_todo || w_todo); cyc++) begin
            if (aw_todo && cyc >= aw_dly) begin awaddr = addr; awvalid = 1'b1; end
            if (w_todo && cyc >= w_dly) begin wdata = data; wstrb = strb; wvalid = 1'b1; end
            if (clash && cyc == 0) begin ip2reg_en = 3'b100; ip2reg_data[2] = clash_data; end
            @(negedge clk);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(posedge clk); #1;
            ip2reg_en = '0;
            if (aw_fire) begin awvalid = 1'b0; aw_todo = 1'b0; end
            if (w_fire) begin wvalid = 1'b0; w_todo = 1'b0; end
        end
        if (aw_todo || w_todo) begin
            awvalid = 1'b0;
            wvalid  = 1'b0;
            fail("wr_accept_timeout", 64'({aw_todo, w_todo}));
            return;
        end
        @(negedge clk);
        check("b_latency", 64'(bvalid), 64'(1));
        check("strobe_timing", 64'(reg2ip_en), 64'(exp_en));
        @(posedge clk); #1;
        for (int k = 0; k < b_dly; k++) begin
            @(negedge clk);
            check("b_hold_valid", 64'(bvalid), 64'(1));
            check("b_hold_awready", 64'(awready), 64'(0));
            check("b_hold_wready", 64'(wready), 64'(0));
            @(posedge clk); #1;
        end
        bready = 1'b1;
        b_fire = 1'b0;
        for (int t = 0; t < 50 && !b_fire; t++) begin
            @(negedge clk);
            b_fire = bvalid && bready;
            @(posedge clk); #1;
        end
        bready = 1'b0;
        if (!b_fire) fail("b_handshake_timeout", 64'(bvalid));
    endtask

    task automatic bus_read(input logic [11:0] addr, input int r_dly, input bit use_ovr, input logic [31:0] ovr);
        int          idx;
        logic [31:0] ev;
        logic [1:0]  er;
        bit          ar_fire, r_fire;
        idx = int'(addr[11:2]);
        if (idx < NREG) begin
            ev = use_ovr ? ovr : model[idx];
            er = RESP_OKAY;
        end else begin
            ev = '0;
            er = RESP_SLVERR;
        end
        exp_r.push_back({ev, er});
        araddr  = addr;
        arvalid = 1'b1;
        ar_fire = 1'b0;
        for (int t = 0; t < 50 && !ar_fire; t++) begin
            @(negedge clk);
            ar_fire = arvalid && arready;
            @(posedge clk); #1;
        end
        arvalid = 1'b0;
        if (!ar_fire) begin fail("ar_timeout", 64'(arready)); return; end
        @(negedge clk);
        check("r_latency", 64'(rvalid), 64'(1));
        @(posedge clk); #1;
        for (int k = 0; k < r_dly; k++) begin
            @(negedge clk);
            check("r_hold_valid", 64'(rvalid), 64'(1));
            @(posedge clk); #1;
        end
        rready = 1'b1;
        r_fire = 1'b0;
        for (int t = 0; t < 50 && !r_fire; t++) begin
            @(negedge clk);
            r_fire = rvalid && rready;
            @(posedge clk); #1;
        end
        rready = 1'b0;
        if (!r_fire) fail("r_handshake_timeout", 64'(rvalid));
    endtask

    task automatic hw_update(input int i, input logic [31:0] d);
        ip2reg_en[i]   = 1'b1;
        ip2reg_data[i] = d;
        @(posedge clk); #1;
        ip2reg_en = '0;
        model[i]  = d;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pre, wd, d;
        logic [11:0] a;
        for (int i = 0; i < NREG; i++) model[i] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_awready", 64'(awready), 0);
        check("rst_wready", 64'(wready), 0);
        check("rst_arready", 64'(arready), 0);
        check("rst_valids", 64'({bvalid, rvalid}), 0);
        check("rst_resps", 64'({bresp, rresp}), 0);
        check("rst_rdata", 64'(rdata), 0);
        check("rst_strobe", 64'(reg2ip_en), 0);
        for (int i = 0; i < NREG; i++) check("rst_reg2ip_data", 64'(reg2ip_data[i]), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        bus_write(REG1_OFFSET, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0, '0);
        hw_update(0, 32'hAAAAAAAA);
        bus_write(REG0_OFFSET, 32'h12345678, 4'h3, 2, 0, 0, 1'b0, '0);
        bus_read(REG0_OFFSET, 1, 1'b0, '0);
        bus_write(12'h00C, 32'h55555555, 4'hF, 0, 0, 0, 1'b0, '0);
        bus_read(12'h00C, 0, 1'b0, '0);
        hw_update(2, 32'h0000CAFE);
        bus_read(REG2_OFFSET, 0, 1'b0, '0);
        bus_write(REG2_OFFSET, 32'h00000001, 4'hF, 0, 0, 0, 1'b1, 32'hBAD0BAD0);
        bus_read(REG2_OFFSET, 0, 1'b0, '0);
        bus_write(REG1_OFFSET, 32'h0F0F0F0F, 4'h0, 0, 0, 5, 1'b0, '0);
        bus_write(REG1_OFFSET, 32'h11223344, 4'h4, 0, 1, 0, 1'b0, '0);

        pre = model[1];
        wd  = $urandom;
        fork
            bus_write(REG1_OFFSET, wd, 4'hF, 0, 0, 0, 1'b0, '0);
            bus_read(REG1_OFFSET, 0, 1'b1, pre);
        join

        awaddr  = REG1_OFFSET;
        awvalid = 1'b1;
        @(negedge clk);
        check("mid_rst_aw_accept", 64'(awready), 64'(1));
        @(posedge clk); #1;
        awvalid = 1'b0;
        wdata   = 32'hFFFFFFFF;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        rst_n   = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        wvalid = 1'b0;
        for (int i = 0; i < NREG; i++) model[i] = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("mid_rst_bvalid", 64'(bvalid), 0);
            check("mid_rst_strobe", 64'(reg2ip_en), 0);
            @(posedge clk); #1;
        end
        for (int i = 0; i < NREG; i++) check("mid_rst_reg2ip_data", 64'(reg2ip_data[i]), 0);
        for (int i = 0; i < NREG; i++) bus_read(12'(4 * i), 0, 1'b0, '0);
        bus_write(REG2_OFFSET, 32'hCAFEF00D, 4'hF, 0, 2, 0, 1'b0, '0);

        for (int n = 0; n < 60; n++) begin
            int op;
            op = $urandom_range(0, 9);
            a  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 15));
            d  = $urandom;
            if (op < 5) begin
                bus_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, '0);
            end else if (op < 8) begin
                bus_read(a, $urandom_range(0, 2), 1'b0, '0);
            end else begin
                hw_update($urandom_range(0, NREG - 1), d);
            end
        end
        for (int i = 0; i < NREG; i++) bus_read(12'(4 * i), 0, 1'b0, '0);

        repeat (3) @(posedge clk);
        #1;
        check("b_queue_empty", 64'(exp_b.size()), 0);
        check("r_queue_empty", 64'(exp_r.size()), 0);
        check("strobe_queue_empty", 64'(exp_s.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/custom_axi_regif.md
Name: custom_axi_regif

Overview:
- AXI4-Lite slave register interface that sits directly upstream of the custom IP core.
- Decodes bus writes into per-register one-cycle `reg2ip` data/enable strobes.
- Holds a shadow copy of each register. The shadow is updated by bus writes and by `ip2reg` hardware updates.
- Serves bus reads from the shadow registers. Sits between the SoC AXI-Lite crossbar port and the IP's reg2ip/ip2reg interface.

Parameters:
- ADDR_WIDTH, 12, AXI-Lite address width; register index = addr[ADDR_WIDTH-1:2].
- DATA_WIDTH, 32, AXI-Lite data width; fixed at 32, elaboration error otherwise.
- NUM_REGS, 3, number of 32-bit registers, at byte offsets 0x0, 0x4, 0x8.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; synchronous, active-low.
- awaddr_i  in  ADDR_WIDTH  write address.
- awvalid_i / awready_o  in/out  1  AW handshake.
- wdata_i  in  32  write data.
- wstrb_i  in  4  byte strobes.
- wvalid_i / wready_o  in/out  1  W handshake.
- bresp_o  out  2  write response.
- bvalid_o / bready_i  out/in  1  B handshake.
- araddr_i  in  ADDR_WIDTH  read address.
- arvalid_i / arready_o  in/out  1  AR handshake.
- rdata_o  out  32  read data.
- rresp_o  out  2  read response.
- rvalid_o / rready_i  out/in  1  R handshake.
- reg2ip_data_o  out  NUM_REGS x 32  post-strobe register value presented to the IP.
- reg2ip_en_o  out  NUM_REGS  one-cycle write pulse per register.
- ip2reg_data_i  in  NUM_REGS x 32  hardware update value.
- ip2reg_en_i  in  NUM_REGS  hardware update enable per register.

Behaviour:
- Reset: all ready/valid outputs 0, bresp_o/rresp_o = OKAY (2'b00), rdata_o = 0, reg2ip_en_o = 0, reg2ip_data_o = 0, shadows = 0. Write and read FSMs return to IDLE; buffered AW/W and pending responses are discarded.
- Reset mid-transaction: no strobe is issued and no B or R response is issued.
- Write path:
  - Separate one-entry AW and W buffers.
  - awready_o = 1 while the AW buffer is empty and the write FSM is in W_IDLE; wready_o likewise for the W buffer.
  - AW and W may arrive in either order or in the same cycle.
  - Commit happens on the first edge where both are held or arriving.
- Commit, for a valid index i (< NUM_REGS):
  - shadow[i] is merged bytewise with wstrb_i.
  - In the next cycle, reg2ip_en_o[i] = 1 for exactly one cycle and reg2ip_data_o[i] = the merged value.
  - bvalid_o = 1 with bresp_o = OKAY in that same cycle.
  - The FSM moves to W_RESP.
- Commit with an invalid index: no strobe, shadow unchanged, bresp_o = SLVERR (2'b10).
- W_RESP: bvalid_o is held until bready_i, then the FSM returns to W_IDLE. No new AW/W is accepted in W_RESP.
- wstrb_i = 0: an OKAY response is still returned and the strobe still fires with the unchanged value.
- reg2ip_data_o[i] holds its last value between strobes.
- Hardware update: ip2reg_en_i[i] = 1 loads ip2reg_data_i[i] into shadow[i] at the edge. No reg2ip strobe is generated.
- Same-edge bus commit and ip2reg_en_i on the same register: the bus write wins.
- Read path:
  - R_IDLE: arready_o = 1.
  - On AR handshake, rdata_o is registered from shadow[index], or 0 with SLVERR if out of range, and rvalid_o rises next cycle. The FSM moves to R_RESP.
  - R_RESP: rdata_o/rresp_o are held stable until rready_i, then the FSM returns to R_IDLE.
  - Read and write paths are fully independent.
  - A read and a commit to the same register on the same edge: the read returns the pre-write shadow.
- Address bits [1:0] are ignored.

Decomposition:
- Package custom_axi_pkg holds:
  - RESP_OKAY/RESP_SLVERR constants.
  - wr_state_e {W_IDLE, W_RESP} and rd_state_e {R_IDLE, R_RESP}.
  - REG_OFFSET constants.
- One natural sub-module: custom_axi_regif_wr, containing the AW/W buffering, the write FSM and the strobe generation.
- The read FSM and shadow array stay in the top level.

Test Plan:
- AW+W same cycle, addr 0x4, data 0xDEADBEEF, wstrb 0xF → next cycle reg2ip_en_o = 3'b010, reg2ip_data_o[1] = 0xDEADBEEF, bvalid_o = 1, bresp_o = 00.
- W two cycles before AW, addr 0x0, data 0x12345678, wstrb 0x3, shadow 0xAAAAAAAA → strobe 1 cycle after AW arrives, reg2ip_data_o[0] = 0xAAAA5678.
- Write to addr 0xC → bresp_o = 10, reg2ip_en_o stays 0. Read 0xC → rresp_o = 10, rdata_o = 0.
- ip2reg_en_i[2] = 1 with 0x0000CAFE, then read addr 0x8 → rvalid_o one cycle after AR, rdata_o = 0x0000CAFE. Same edge as a bus write 0x1 to reg2 → the shadow holds 0x1.
- bready_i held low 5 cycles → bvalid_o stays high, awready_o/wready_o stay 0, and a second write is accepted only after the B handshake.
- rst_ni low for one cycle while AW is buffered and W is pending → no strobe, no bvalid, all shadows read back 0.
